rc4_phase_sequencer: RTL and testbench
======================================

Name: rc4_phase_sequencer

Overview:
Top-level scheduler that drives the shared-RAM controller through the RC4 phases: S-array init, key-schedule shuffle, then decrypt, once per candidate key. It issues mode/start to the controller and watches its per-phase finished bits. After each decrypt it checks a plaintext-valid flag and steps the key across a programmable range until a key is accepted, the range is exhausted, or a phase times out.

Parameters:
RAM_WIDTH, 8, byte width of RAM words and key bytes
KEY_LENGTH, 3, key bytes; key vector width KW = KEY_LENGTH*RAM_WIDTH
TIMEOUT_CYCLES, 4096, max cycles allowed in any single phase wait before error

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
go  in  1  start a key search; sampled only in IDLE or DONE
key_start  in  KW  first candidate key; byte 0 is the least significant byte
key_end  in  KW  last candidate key (inclusive)
phase_finished  in  3  controller finished bits: [0] init, [1] shuffle, [2] decrypt
msg_valid  in  1  decrypt checker verdict; sampled in CHECK only
mode  out  3  controller mode: 001 init, 010 shuffle, 100 decrypt, 000 idle
start  out  1  one-cycle start pulse to the controller
key  out  KW  current candidate key
attempts  out  KW  number of keys fully tried (decrypt completed)
busy  out  1  high from LOAD until entry to DONE
done  out  1  high in DONE
key_found  out  1  valid when done; 1 = key accepted
timeout_err  out  1  valid when done; 1 = phase watchdog expired

Behaviour:
- Reset (reset=0, async): state IDLE. mode=000, start=0, key=0, attempts=0, busy=0, done=0, key_found=0, timeout_err=0, watchdog=0.
- States: IDLE, LOAD, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT, DEC_GO, DEC_WAIT, CHECK, NEXT_KEY, DONE.
- IDLE/DONE: go=1 -> LOAD. Entering LOAD clears done, key_found, timeout_err and attempts, and loads key <= key_start. go in any other state is ignored.
- LOAD -> INIT_GO, unconditionally.
- *_GO (1 cycle each):
  - start=1 with mode set to the phase encoding; watchdog cleared; next state is the matching *_WAIT.
- *_WAIT:
  - mode is held at the phase encoding and start=0.
  - Advance on the rising edge of the phase's finished bit, detected against a register of the previous cycle's value. A level that is already high on WAIT entry does not advance.
  - Transitions: INIT_WAIT -> SHUF_GO; SHUF_WAIT -> DEC_GO; DEC_WAIT -> CHECK with attempts+1.
- Watchdog:
  - Increments each cycle in a WAIT state.
  - If it reaches TIMEOUT_CYCLES-1 with no edge: -> DONE with timeout_err=1, key_found=0.
  - An edge in that same cycle wins over the timeout.
- CHECK (1 cycle, mode=000):
  - msg_valid=1 -> DONE, key_found=1; key holds the accepted key.
  - Otherwise, key==key_end -> DONE, key_found=0.
  - Otherwise -> NEXT_KEY.
- NEXT_KEY: key <= key+1 modulo 2^KW (wraps all-ones to 0, so key_start > key_end searches through the wrap) -> INIT_GO.
- Latency: go sampled at edge N; LOAD at N+1; first start pulse (mode=001) visible at N+2.
- mode is 000 in IDLE, LOAD, CHECK, NEXT_KEY and DONE. Outputs are registered (Moore) except start, which decodes from *_GO.
- Reset mid-operation forces IDLE immediately, and mode=000 combinationally via state reset. No start pulse is emitted after reset until a new go.
- Simultaneous finished edges on non-selected bits are ignored; only the active phase bit counts.

Test Plan:
- Single key, accepted: key_start=key_end=0x000249. Finished edges 5, 7, 9 cycles after each start; msg_valid=1 in CHECK -> mode sequence 001/010/100, exactly 3 start pulses, done=1, key_found=1, key=0x000249, attempts=1.
- Range exhausted: key 0x000010..0x000012, msg_valid always 0 -> 9 start pulses; done with key_found=0, key=0x000012, attempts=3.
- Wrap-around: key_start=0xFFFFFE, key_end=0x000001, msg_valid=1 on the 3rd key -> keys tried FFFFFE, FFFFFF, 000000; final key=0x000000, attempts=3.
- Watchdog: TIMEOUT_CYCLES=16, shuffle finished never rises -> done=1, timeout_err=1, key_found=0 exactly 15 cycles after SHUF_WAIT entry. Also: finished edge on the same cycle as expiry -> normal advance, no error.
- Stale level: phase_finished[0] held 1 before go -> sequencer waits in INIT_WAIT until a fresh 0->1 edge; no premature advance.
- Reset mid-search: assert reset during DEC_WAIT -> same cycle mode=000, busy=0, key=0. After release, go restarts from key_start with attempts=0. Also: go pulsed while busy -> ignored, search unaffected.

Source files
------------

// File: rtl/rc4_phase_sequencer.sv
// RC4 phase scheduler: runs init, shuffle and decrypt on the shared-RAM controller
// for each candidate key until a key is accepted, the range runs out, or a phase stalls.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for go after reset
// LOAD       | clear result flags, load first candidate key
// INIT_GO    | start pulse, mode=init
// INIT_WAIT  | wait for init finished edge (watchdog running)
// SHUF_GO    | start pulse, mode=shuffle
// SHUF_WAIT  | wait for shuffle finished edge (watchdog running)
// DEC_GO     | start pulse, mode=decrypt
// DEC_WAIT   | wait for decrypt finished edge, then count the attempt
// CHECK      | sample msg_valid, decide accept / exhausted / next
// NEXT_KEY   | step key by one, wrapping modulo 2^KW
// DONE       | result valid; go restarts a search
module rc4_phase_sequencer #(
  parameter int  RAM_WIDTH      = 8,
  parameter int  KEY_LENGTH     = 3,
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int KW             = KEY_LENGTH * RAM_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic [KW-1:0] key_start,
  input  logic [KW-1:0] key_end,
  input  logic [2:0]    phase_finished,
  input  logic          msg_valid,
  output logic [2:0]    mode,
  output logic          start,
  output logic [KW-1:0] key,
  output logic [KW-1:0] attempts,
  output logic          busy,
  output logic          done,
  output logic          key_found,
  output logic          timeout_err
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  // Down-counter holds the WAIT cycles left before expiry; zero means this is the last one.
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT_CYCLES - 2);

  localparam logic [2:0] MODE_IDLE = 3'b000;
  localparam logic [2:0] MODE_INIT = 3'b001;
  localparam logic [2:0] MODE_SHUF = 3'b010;
  localparam logic [2:0] MODE_DEC  = 3'b100;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_INIT_GO, ST_INIT_WAIT, ST_SHUF_GO, ST_SHUF_WAIT,
    ST_DEC_GO, ST_DEC_WAIT, ST_CHECK, ST_NEXT_KEY, ST_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      mode_nxt;
  logic [2:0]      fin_q;
  logic [WDW-1:0]  wd_cnt;
  logic            fin_rise_act;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == '0);

  always_comb begin
    state_nxt    = state;
    mode_nxt     = MODE_IDLE;
    start        = 1'b0;
    fin_rise_act = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (go) state_nxt = ST_LOAD;
      ST_LOAD:          state_nxt = ST_INIT_GO;
      ST_INIT_GO: begin
        start     = 1'b1;
        state_nxt = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        fin_rise_act = phase_finished[0] & ~fin_q[0];
        if (fin_rise_act)    state_nxt = ST_SHUF_GO;
        else if (wd_expired) state_nxt = ST_DONE;
      end
      ST_SHUF_GO: begin
        start     = 1'b1;
        state_nxt = ST_SHUF_WAIT;
      end
      ST_SHUF_WAIT: begin
        fin_rise_act = phase_finished[1] & ~fin_q[1];
        if (fin_rise_act)    state_nxt = ST_DEC_GO;
        else if (wd_expired) state_nxt = ST_DONE;
      end
      ST_DEC_GO: begin
        start     = 1'b1;
        state_nxt = ST_DEC_WAIT;
      end
      ST_DEC_WAIT: begin
        fin_rise_act = phase_finished[2] & ~fin_q[2];
        if (fin_rise_act)    state_nxt = ST_CHECK;
        else if (wd_expired) state_nxt = ST_DONE;
      end
      ST_CHECK: begin
        if (msg_valid || (key == key_end)) state_nxt = ST_DONE;
        else                               state_nxt = ST_NEXT_KEY;
      end
      ST_NEXT_KEY: state_nxt = ST_INIT_GO;
      default:     state_nxt = ST_IDLE;
    endcase

    // mode is registered from the next state so it is glitch-free for the whole phase
    case (state_nxt)
      ST_INIT_GO, ST_INIT_WAIT: mode_nxt = MODE_INIT;
      ST_SHUF_GO, ST_SHUF_WAIT: mode_nxt = MODE_SHUF;
      ST_DEC_GO,  ST_DEC_WAIT:  mode_nxt = MODE_DEC;
      default:                  mode_nxt = MODE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      mode        <= MODE_IDLE;
      fin_q       <= '0;
      wd_cnt      <= '0;
      key         <= '0;
      attempts    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      key_found   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
      fin_q <= phase_finished;
      busy  <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      done  <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            key         <= key_start;
            attempts    <= '0;
            key_found   <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        ST_INIT_GO, ST_SHUF_GO, ST_DEC_GO: wd_cnt <= WD_LOAD;
        ST_INIT_WAIT, ST_SHUF_WAIT, ST_DEC_WAIT: begin
          if (fin_rise_act) begin
            if (state == ST_DEC_WAIT) attempts <= attempts + KW'(1);
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - WDW'(1);
          end
        end
        ST_CHECK:    if (msg_valid) key_found <= 1'b1;
        ST_NEXT_KEY: key <= key + KW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Self-checking bench for rc4_phase_sequencer: an emulated RAM controller answers each
// start pulse, and a search-level model predicts keys, pulse timing and final results.
module tb_rc4_phase_sequencer;
  localparam int KW  = 24;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [KW-1:0] key_start;
  logic [KW-1:0] key_end;
  logic [2:0]    phase_finished;
  logic          msg_valid;
  logic [2:0]    mode;
  logic          start;
  logic [KW-1:0] key;
  logic [KW-1:0] attempts;
  logic          busy;
  logic          done;
  logic          key_found;
  logic          timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rc4_phase_sequencer #(.RAM_WIDTH(8), .KEY_LENGTH(3), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .go(go), .key_start(key_start), .key_end(key_end),
    .phase_finished(phase_finished), .msg_valid(msg_valid), .mode(mode), .start(start),
    .key(key), .attempts(attempts), .busy(busy), .done(done), .key_found(key_found),
    .timeout_err(timeout_err)
  );

  // Runs one search. Phase p finishes d_p cycles after its start pulse (bit dropped one
  // cycle before, so stale highs from earlier phases never count). A delay >= TMO never
  // finishes in time. abort_dec>0 returns mid-way through that key's decrypt wait.
  task automatic run_search(input logic [KW-1:0] ks, input logic [KW-1:0] ke, input int acc,
                            input int d0, input int d1, input int d2, input int abort_dec,
                            input bit pre_stale, output bit aborted);
    int dly[3];
    logic [KW-1:0] diff, exp_key, cur_key;
    int n_keys, tried, exp_starts, to_phase, egap;
    bit exp_found, exp_to, done_seen;
    int cyc, starts, pend, cnt, last_start, last_ph, done_cyc, ph;
    logic [2:0] exp_mode;
    logic [31:0] r;

    dly = '{d0, d1, d2};
    aborted = 1'b0;
    to_phase = -1;
    for (int p = 0; p < 3; p++) if (to_phase < 0 && dly[p] >= TMO) to_phase = p;
    diff = ke - ks;
    n_keys = int'(diff) + 1;
    if (to_phase >= 0) begin
      exp_to = 1'b1; exp_found = 1'b0; tried = 0;
      exp_starts = to_phase + 1; exp_key = ks;
    end else begin
      exp_to = 1'b0;
      exp_found = (acc >= 0) && (acc < n_keys);
      tried = exp_found ? acc + 1 : n_keys;
      exp_starts = 3 * tried;
      exp_key = ks + KW'(tried - 1);
    end

    @(negedge clk);
    key_start = ks; key_end = ke; go = 1'b1;
    if (pre_stale) phase_finished[0] = 1'b1;

    cyc = 0; starts = 0; pend = -1; cnt = 0; last_start = 0; last_ph = 0;
    done_cyc = 0; done_seen = 1'b0;
    while (!done_seen && !aborted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b expected 1", busy); end
      end
      if (start === 1'b1) begin
        ph = starts % 3;
        cur_key = ks + KW'(starts / 3);
        exp_mode = 3'b001 << ph;
        egap = (starts == 0) ? 2 : ((last_ph == 2) ? dly[2] + 3 : dly[last_ph] + 1);
        n_checks++;
        if (mode !== exp_mode) begin
          n_fail++; $display("FAIL start_mode: pulse %0d got %b expected %b", starts, mode, exp_mode);
        end
        n_checks++;
        if (key !== cur_key) begin
          n_fail++; $display("FAIL start_key: pulse %0d got %h expected %h", starts, key, cur_key);
        end
        n_checks++;
        if (cyc - last_start != egap) begin
          n_fail++; $display("FAIL start_gap: pulse %0d got %0d expected %0d", starts, cyc - last_start, egap);
        end
        starts++; last_start = cyc; last_ph = ph; pend = ph; cnt = dly[ph];
        r = $urandom; msg_valid = r[0];
      end else if (pend >= 0) begin
        r = $urandom;
        for (int b = 0; b < 3; b++)
          if (b != pend && r[2*b +: 2] == 2'b00) phase_finished[b] = ~phase_finished[b];
        cnt--;
        if (cnt == 1) phase_finished[pend] = 1'b0;
        else if (cnt == 0) begin
          phase_finished[pend] = 1'b1;
          if (pend == 2) msg_valid = ((starts - 1) / 3 == acc);
          pend = -1;
        end
        if (abort_dec > 0 && starts == 3 * abort_dec && pend == 2 && cnt == 2) aborted = 1'b1;
      end
      if (done === 1'b1) begin done_seen = 1'b1; done_cyc = cyc; end
      go = (busy === 1'b1 && done !== 1'b1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    go = 1'b0;
    if (aborted) return;

    n_checks++;
    if (!done_seen) begin n_fail++; $display("FAIL done_reached: no done within %0d cycles", cyc); end
    n_checks++;
    if (key !== exp_key) begin n_fail++; $display("FAIL final_key: got %h expected %h", key, exp_key); end
    n_checks++;
    if (attempts !== KW'(tried)) begin n_fail++; $display("FAIL attempts: got %0d expected %0d", attempts, tried); end
    n_checks++;
    if (key_found !== exp_found) begin n_fail++; $display("FAIL key_found: got %b expected %b", key_found, exp_found); end
    n_checks++;
    if (timeout_err !== exp_to) begin n_fail++; $display("FAIL timeout_err: got %b expected %b", timeout_err, exp_to); end
    n_checks++;
    if (starts != exp_starts) begin n_fail++; $display("FAIL start_count: got %0d expected %0d", starts, exp_starts); end
    n_checks++;
    if (busy !== 1'b0 || mode !== 3'b000) begin
      n_fail++; $display("FAIL done_outputs: busy %b mode %b expected 0 000", busy, mode);
    end
    egap = exp_to ? TMO : dly[2] + 2;
    n_checks++;
    if (done_cyc - last_start != egap) begin
      n_fail++; $display("FAIL done_latency: got %0d expected %0d", done_cyc - last_start, egap);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; go = 1'b0; key_start = '0; key_end = '0; phase_finished = '0; msg_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mode, start, busy, done, key_found, timeout_err} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000000", {mode, start, busy, done, key_found, timeout_err});
    end
    n_checks++;
    if (key !== '0 || attempts !== '0) begin
      n_fail++; $display("FAIL reset_regs: key %h attempts %h expected 0 0", key, attempts);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (start !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet: start %b busy %b expected 0 0", start, busy);
    end
  endtask

  task automatic test_single_key();
    bit ab;
    run_search(24'h000249, 24'h000249, 0, 5, 7, 9, 0, 1'b0, ab);
  endtask

  task automatic test_range_exhausted();
    bit ab;
    run_search(24'h000010, 24'h000012, -1, 4, 6, 8, 0, 1'b0, ab);
  endtask

  task automatic test_wrap();
    bit ab;
    run_search(24'hFFFFFE, 24'h000001, 2, 3, 5, 7, 0, 1'b0, ab);
  endtask

  task automatic test_watchdog();
    bit ab;
    run_search(24'h000020, 24'h000025, -1, 4, TMO, 4, 0, 1'b0, ab);
    run_search(24'h000020, 24'h000020, 0, 4, TMO - 1, 4, 0, 1'b0, ab);
  endtask

  task automatic test_stale_level();
    bit ab;
    phase_finished = 3'b001;
    run_search(24'h000030, 24'h000031, 1, 10, 3, 3, 0, 1'b1, ab);
  endtask

  task automatic test_reset_mid();
    bit ab;
    run_search(24'h000100, 24'h000105, -1, 3, 3, 10, 2, 1'b0, ab);
    n_checks++;
    if (!ab) begin n_fail++; $display("FAIL abort_point: got %b expected 1", ab); end
    n_checks++;
    if (attempts !== 24'd1 || key !== 24'h000101) begin
      n_fail++; $display("FAIL mid_state: attempts %0d key %h expected 1 000101", attempts, key);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (mode !== 3'b000 || busy !== 1'b0 || key !== '0 || start !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: mode %b busy %b key %h start %b expected 000 0 0 0", mode, busy, key, start);
    end
    @(negedge clk);
    reset = 1'b1; phase_finished = '0; msg_valid = 1'b0; go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (start !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_idle: cycle %0d start %b busy %b expected 0 0", i, start, busy);
      end
    end
    run_search(24'h000100, 24'h000101, 1, 3, 3, 3, 0, 1'b0, ab);
  endtask

  task automatic test_back_to_back();
    bit ab;
    logic [31:0] r;
    logic [KW-1:0] ks;
    for (int t = 0; t < 8; t++) begin
      r = $urandom;
      ks = (t % 3 == 0) ? 24'hFFFFFF - KW'($urandom_range(0, 2)) : r[KW-1:0];
      run_search(ks, ks + KW'($urandom_range(0, 3)), $urandom_range(0, 4) - 1,
                 $urandom_range(2, 14), $urandom_range(2, 14), $urandom_range(2, 14), 0, 1'b0, ab);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (start !== 1'b0 || done !== 1'b1) begin
        n_fail++; $display("FAIL done_hold: cycle %0d start %b done %b expected 0 1", i, start, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_range_exhausted();
    test_wrap();
    test_watchdog();
    test_stale_level();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1);
  end
endmodule
